// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I load/store width codes (func3)
//   - FSM state encoding
//   - default memory acknowledge timeout
//   - request legality helper (width code + effective-address alignment)
package lsu_pkg;

  localparam logic [2:0] Func3B  = 3'b000;
  localparam logic [2:0] Func3H  = 3'b001;
  localparam logic [2:0] Func3W  = 3'b010;
  localparam logic [2:0] Func3Bu = 3'b100;
  localparam logic [2:0] Func3Hu = 3'b101;

  // Cycles spent in MEM without an acknowledge before the access is abandoned.
  localparam int unsigned LsuTimeoutDefault = 255;

  typedef enum logic [1:0] {
    StIdle,
    StMem,
    StResp
  } lsu_state_e;

  // A request is legal when its width code exists for its direction and the
  // effective address is naturally aligned for that width.
  function automatic logic lsu_req_legal(input logic       is_store,
                                         input logic [2:0] func3,
                                         input logic [1:0] ea_lo);
    logic legal;
    legal = 1'b0;
    case (func3)
      Func3B:  legal = 1'b1;
      Func3H:  legal = ~ea_lo[0];
      Func3W:  legal = (ea_lo == 2'b00);
      Func3Bu: legal = ~is_store;
      Func3Hu: legal = ~is_store & ~ea_lo[0];
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic shared by the store and load paths.
//   func3_i    : access width code
//   offset_i   : effective address bits [1:0]
//   st_data_i  : raw store data (rs2)
//   st_data_o  : store data replicated across the byte lanes
//   st_strb_o  : byte strobes for the addressed lanes
//   ld_word_i  : raw read word from memory
//   ld_data_o  : selected lane, sign- or zero-extended to 32 bits
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_data_o,
  output logic [3:0]  st_strb_o,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: replicating the data means the strobes alone pick the lane.
  always_comb begin
    st_data_o = st_data_i;
    st_strb_o = 4'b1111;
    case (func3_i)
      Func3B: begin
        st_data_o = {4{st_data_i[7:0]}};
        st_strb_o = 4'b0001 << offset_i;
      end
      Func3H: begin
        st_data_o = {2{st_data_i[15:0]}};
        st_strb_o = 4'b0011 << offset_i;
      end
      default: begin
        st_data_o = st_data_i;
        st_strb_o = 4'b1111;
      end
    endcase
  end

  // Load side: halfword accesses are always even, so offset_i[1] picks the half.
  always_comb begin
    ld_byte = ld_word_i[7:0];
    unique case (offset_i)
      2'b00: ld_byte = ld_word_i[7:0];
      2'b01: ld_byte = ld_word_i[15:8];
      2'b10: ld_byte = ld_word_i[23:16];
      2'b11: ld_byte = ld_word_i[31:24];
      default: ld_byte = ld_word_i[7:0];
    endcase
    ld_half = offset_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

    ld_data_o = ld_word_i;
    case (func3_i)
      Func3B:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      Func3H:  ld_data_o = {{16{ld_half[15]}}, ld_half};
      Func3Bu: ld_data_o = {24'h0, ld_byte};
      Func3Hu: ld_data_o = {16'h0, ld_half};
      default: ld_data_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access stage, one transaction in flight.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_*                 : request from control_unit (valid/ready), base+imm addressing
//   mem_*                 : word-wide request/acknowledge memory port with byte strobes
//   resp_*                : load result / store completion to writeback (valid/ready)
// Flow: IDLE accepts and checks legality; legal requests go to MEM and wait for
// mem_ack (bounded by TIMEOUT), illegal ones go straight to RESP with resp_err.
// RESP holds its outputs until resp_ready, then returns to IDLE.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = LsuTimeoutDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_imm,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_err
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  lsu_state_e  state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  func3_q, func3_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;

  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [4:0]  resp_rd_q, resp_rd_d;
  logic        resp_err_q, resp_err_d;

  logic [31:0] ea;
  logic        req_legal;
  logic [7:0]  cnt_inc;
  logic [2:0]  al_func3;
  logic [1:0]  al_offset;
  logic [31:0] al_st_data;
  logic [3:0]  al_st_strb;
  logic [31:0] al_ld_data;

  assign ea        = req_base + req_imm;
  assign req_legal = lsu_req_legal(req_is_store, req_func3, ea[1:0]);
  assign cnt_inc   = cnt_q + 8'd1;

  // The aligner serves the incoming request while idle (store lanes) and the
  // captured request afterwards (load extension on ack).
  assign al_func3  = (state_q == StIdle) ? req_func3 : func3_q;
  assign al_offset = (state_q == StIdle) ? ea[1:0]   : off_q;

  lsu_align u_align (
    .func3_i   (al_func3),
    .offset_i  (al_offset),
    .st_data_i (req_wdata),
    .st_data_o (al_st_data),
    .st_strb_o (al_st_strb),
    .ld_word_i (mem_rdata),
    .ld_data_o (al_ld_data)
  );

  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    func3_d      = func3_q;
    off_d        = off_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_rd_d    = resp_rd_q;
    resp_err_d   = resp_err_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          is_store_d = req_is_store;
          func3_d    = req_func3;
          off_d      = ea[1:0];
          rd_d       = req_rd;
          if (req_legal) begin
            state_d     = StMem;
            cnt_d       = 8'd0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_is_store;
            mem_addr_d  = {ea[31:2], 2'b00};
            mem_wdata_d = req_is_store ? al_st_data : 32'h0;
            mem_wstrb_d = req_is_store ? al_st_strb : 4'b0000;
          end else begin
            // No memory access is made for an illegal request.
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = 32'h0;
            resp_rd_d    = req_is_store ? 5'd0 : req_rd;
          end
        end
      end

      StMem: begin
        // An ack in the cycle the counter expires still wins.
        if (mem_ack || (cnt_inc == TimeoutCnt)) begin
          state_d      = StResp;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_addr_d   = 32'h0;
          mem_wdata_d  = 32'h0;
          mem_wstrb_d  = 4'b0000;
          resp_valid_d = 1'b1;
          resp_err_d   = ~mem_ack;
          resp_data_d  = (mem_ack && !is_store_q) ? al_ld_data : 32'h0;
          resp_rd_d    = is_store_q ? 5'd0 : rd_q;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      StResp: begin
        if (resp_ready) begin
          state_d      = StIdle;
          resp_valid_d = 1'b0;
          resp_data_d  = 32'h0;
          resp_rd_d    = 5'd0;
          resp_err_d   = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      is_store_q   <= 1'b0;
      func3_q      <= 3'b000;
      off_q        <= 2'b00;
      rd_q         <= 5'd0;
      cnt_q        <= 8'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_wstrb_q  <= 4'b0000;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_rd_q    <= 5'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      func3_q      <= func3_d;
      off_q        <= off_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_rd_q    <= resp_rd_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_rd    = resp_rd_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit. Expected responses
// come from a small behavioural model and are queued when a request is sent.
module tb_load_store_unit;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
  } resp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_func3;
  logic [31:0] req_base;
  logic [31:0] req_imm;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;

  int checks = 0;
  int errors = 0;
  resp_t sb[$];

  load_store_unit #(.TIMEOUT(255)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_func3    (req_func3),
    .req_base     (req_base),
    .req_imm      (req_imm),
    .req_wdata    (req_wdata),
    .req_rd       (req_rd),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_rd      (resp_rd),
    .resp_err     (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit m_legal(input bit st, input logic [2:0] f3, input logic [31:0] ea);
    case (f3)
      3'b000:  return 1'b1;
      3'b001:  return ea[0] == 1'b0;
      3'b010:  return ea[1:0] == 2'b00;
      3'b100:  return !st;
      3'b101:  return !st && (ea[0] == 1'b0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic resp_t m_resp(input bit st, input logic [2:0] f3, input logic [31:0] ea,
                                   input logic [31:0] rdata, input logic [4:0] rd,
                                   input bit timed_out);
    resp_t r;
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[8*ea[1:0] +: 8];
    h = rdata[16*ea[1] +: 16];
    r.err  = !m_legal(st, f3, ea) || timed_out;
    r.rd   = st ? 5'd0 : rd;
    r.data = 32'h0;
    if (!st && !r.err) begin
      case (f3)
        3'b000:  r.data = {{24{b[7]}}, b};
        3'b001:  r.data = {{16{h[15]}}, h};
        3'b100:  r.data = {24'h0, b};
        3'b101:  r.data = {16'h0, h};
        default: r.data = rdata;
      endcase
    end
    return r;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [1:0] off);
    if (f3 == 3'b000) return 4'b0001 << off;
    if (f3 == 3'b001) return 4'b0011 << off;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3 == 3'b000) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    if (f3 == 3'b001) return {wd[15:0], wd[15:0]};
    return wd;
  endfunction

  // ---------------- drivers (called at a negedge, return at a negedge) ----------------
  task automatic send_req(input bit st, input logic [2:0] f3, input logic [31:0] base,
                          input logic [31:0] imm, input logic [31:0] wd, input logic [4:0] rd);
    req_is_store = st;
    req_func3    = f3;
    req_base     = base;
    req_imm      = imm;
    req_wdata    = wd;
    req_rd       = rd;
    req_valid    = 1'b1;
    @(negedge clk);
    req_valid    = 1'b0;
  endtask

  // Ack in the delay-th MEM cycle (1 = the cycle right after accept).
  task automatic mem_respond(input int delay, input logic [31:0] rdata);
    repeat (delay - 1) @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic wait_resp(output resp_t obs);
    int i;
    i = 0;
    while (resp_valid !== 1'b1 && i < 400) begin
      @(negedge clk);
      i++;
    end
    if (resp_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL resp_wait resp_valid=%b required 1 within 400 cycles", resp_valid);
    end
    obs.data = resp_data;
    obs.rd   = resp_rd;
    obs.err  = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, resp_valid, resp_data,
         resp_rd, resp_err} !== {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 5'd0, 1'b0})
      begin
      errors++;
      $display("FAIL reset_hold req_ready=%b mem_req=%b addr=%h resp_valid=%b data=%h required 1 0 0 0 0",
               req_ready, mem_req, mem_addr, resp_valid, resp_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, mem_req, resp_valid, mem_wstrb} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL reset_release req_ready=%b mem_req=%b resp_valid=%b strb=%b required 1 0 0 0000",
               req_ready, mem_req, resp_valid, mem_wstrb);
    end
  endtask

  task automatic test_load_byte();
    resp_t obs, exp;
    sb.push_back(m_resp(1'b0, 3'b000, 32'h1003, 32'h80FF_0000, 5'd5, 1'b0));
    send_req(1'b0, 3'b000, 32'h1000, 32'd3, 32'h0, 5'd5);
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wstrb, req_ready} !== {1'b1, 1'b0, 32'h1000, 4'h0, 1'b0})
      begin
      errors++;
      $display("FAIL lb_mem req=%b we=%b addr=%h strb=%b ready=%b required 1 0 00001000 0000 0",
               mem_req, mem_we, mem_addr, mem_wstrb, req_ready);
    end
    mem_respond(1, 32'h80FF_0000);
    checks++;
    if (resp_valid !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL lb_latency resp_valid=%b mem_req=%b required 1 0", resp_valid, mem_req);
    end
    wait_resp(obs);
    exp = sb.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL lb_resp got %h/%0d/%b required %h/%0d/%b", obs.data, obs.rd, obs.err,
               exp.data, exp.rd, exp.err);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL lb_retire req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_load_half();
    resp_t obs, exp;
    logic [2:0]  f3s  [2] = '{3'b101, 3'b001};
    logic [31:0] base [2] = '{32'h2000, 32'h2010};
    logic [31:0] imm  [2] = '{32'h2, 32'hFFFF_FFF2};
    for (int i = 0; i < 2; i++) begin
      sb.push_back(m_resp(1'b0, f3s[i], base[i] + imm[i], 32'hBEEF_1234, 5'd9, 1'b0));
      send_req(1'b0, f3s[i], base[i], imm[i], 32'h0, 5'd9);
      checks++;
      if (mem_addr !== 32'h2000 || mem_req !== 1'b1) begin
        errors++;
        $display("FAIL lh_addr[%0d] addr=%h req=%b required 00002000 1", i, mem_addr, mem_req);
      end
      mem_respond(3, 32'hBEEF_1234);
      wait_resp(obs);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL lh_resp[%0d] got %h/%0d/%b required %h/%0d/%b", i, obs.data, obs.rd,
                 obs.err, exp.data, exp.rd, exp.err);
      end
    end
  endtask

  task automatic test_store();
    resp_t obs, exp;
    logic [2:0]  f3s [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] imm [3] = '{32'h1, 32'h2, 32'h4};
    logic [31:0] ea;
    for (int i = 0; i < 3; i++) begin
      ea = 32'h3000 + imm[i];
      sb.push_back(m_resp(1'b1, f3s[i], ea, 32'h0, 5'd7, 1'b0));
      send_req(1'b1, f3s[i], 32'h3000, imm[i], 32'h1234_56AB, 5'd7);
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata} !==
          {1'b1, 1'b1, ea & 32'hFFFF_FFFC, m_strb(f3s[i], ea[1:0]), m_wdata(f3s[i], 32'h1234_56AB)})
        begin
        errors++;
        $display("FAIL st_mem[%0d] req=%b we=%b addr=%h strb=%b wdata=%h required 1 1 %h %b %h",
                 i, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, ea & 32'hFFFF_FFFC,
                 m_strb(f3s[i], ea[1:0]), m_wdata(f3s[i], 32'h1234_56AB));
      end
      mem_respond(2, 32'h5555_AAAA);
      wait_resp(obs);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL st_resp[%0d] got %h/%0d/%b required %h/%0d/%b", i, obs.data, obs.rd,
                 obs.err, exp.data, exp.rd, exp.err);
      end
    end
  endtask

  task automatic test_errors();
    resp_t obs, exp;
    bit          st  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s [4] = '{3'b010, 3'b111, 3'b100, 3'b001};
    logic [31:0] imm [4] = '{32'h2, 32'h0, 32'h0, 32'h1};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(m_resp(st[i], f3s[i], 32'h4000 + imm[i], 32'h0, 5'd3, 1'b0));
      send_req(st[i], f3s[i], 32'h4000, imm[i], 32'hFFFF_FFFF, 5'd3);
      checks++;
      if ({mem_req, resp_valid, resp_err} !== 3'b011) begin
        errors++;
        $display("FAIL err_early[%0d] mem_req=%b resp_valid=%b resp_err=%b required 0 1 1",
                 i, mem_req, resp_valid, resp_err);
      end
      wait_resp(obs);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL err_resp[%0d] got %h/%0d/%b required %h/%0d/%b", i, obs.data, obs.rd,
                 obs.err, exp.data, exp.rd, exp.err);
      end
    end
  endtask

  task automatic test_timeout();
    resp_t obs, exp;
    int n;
    sb.push_back(m_resp(1'b0, 3'b010, 32'h7000, 32'h0, 5'd11, 1'b1));
    send_req(1'b0, 3'b010, 32'h7000, 32'h0, 32'h0, 5'd11);
    n = 0;
    while (mem_req === 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 255) begin
      errors++;
      $display("FAIL timeout_len mem_req cycles=%0d required 255", n);
    end
    wait_resp(obs);
    exp = sb.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL timeout_resp got %h/%0d/%b required %h/%0d/%b", obs.data, obs.rd, obs.err,
               exp.data, exp.rd, exp.err);
    end
    // Ack in the last allowed cycle is a normal completion.
    sb.push_back(m_resp(1'b0, 3'b010, 32'h7004, 32'h1234_5678, 5'd12, 1'b0));
    send_req(1'b0, 3'b010, 32'h7000, 32'h4, 32'h0, 5'd12);
    mem_respond(255, 32'h1234_5678);
    wait_resp(obs);
    exp = sb.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL ack255_resp got %h/%0d/%b required %h/%0d/%b", obs.data, obs.rd, obs.err,
               exp.data, exp.rd, exp.err);
    end
  endtask

  task automatic test_backpressure();
    resp_t obs, exp, snap;
    sb.push_back(m_resp(1'b0, 3'b010, 32'h6000, 32'hCAFE_F00D, 5'd20, 1'b0));
    send_req(1'b0, 3'b010, 32'h6000, 32'h0, 32'h0, 5'd20);
    mem_respond(2, 32'hCAFE_F00D);
    snap.data = resp_data;
    snap.rd   = resp_rd;
    snap.err  = resp_err;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || mem_req !== 1'b0 ||
          {resp_data, resp_rd, resp_err} !== snap) begin
        errors++;
        $display("FAIL bp_hold[%0d] valid=%b ready=%b mem_req=%b data=%h required 1 0 0 %h",
                 i, resp_valid, req_ready, mem_req, resp_data, snap.data);
      end
      // Stray request and ack while in RESP must both be ignored.
      req_valid = 1'b1;
      mem_ack   = 1'b1;
      mem_rdata = 32'h0BAD_0BAD;
      @(negedge clk);
    end
    req_valid = 1'b0;
    mem_ack   = 1'b0;
    wait_resp(obs);
    exp = sb.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL bp_resp got %h/%0d/%b required %h/%0d/%b", obs.data, obs.rd, obs.err,
               exp.data, exp.rd, exp.err);
    end
    checks++;
    if (req_ready !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL bp_retire req_ready=%b mem_req=%b required 1 0", req_ready, mem_req);
    end
  endtask

  task automatic test_reset_mid();
    send_req(1'b0, 3'b010, 32'h5000, 32'h0, 32'h0, 5'd4);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mem mem_req=%b resp_valid=%b required 0 0", mem_req, resp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, resp_valid, resp_data,
         resp_rd, resp_err} !== {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 5'd0, 1'b0})
      begin
      errors++;
      $display("FAIL rst_after req_ready=%b mem_req=%b addr=%h strb=%b resp_valid=%b required 1 0 0 0 0",
               req_ready, mem_req, mem_addr, mem_wstrb, resp_valid);
    end
    // Reset while a response is pending.
    send_req(1'b0, 3'b111, 32'h5000, 32'h0, 32'h0, 5'd4);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rd !== 5'd0) begin
      errors++;
      $display("FAIL rst_resp resp_valid=%b resp_err=%b resp_rd=%0d required 0 0 0",
               resp_valid, resp_err, resp_rd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    resp_t obs, exp;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] base, imm, wd, rdata, ea;
    logic [4:0]  rd;
    int          delay;
    for (int i = 0; i < 24; i++) begin
      st    = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      base  = $urandom;
      imm   = 32'($urandom_range(0, 15)) - 32'd8;
      wd    = $urandom;
      rdata = $urandom;
      rd    = 5'($urandom_range(1, 31));
      delay = $urandom_range(1, 4);
      ea    = base + imm;
      sb.push_back(m_resp(st, f3, ea, rdata, rd, 1'b0));
      send_req(st, f3, base, imm, wd, rd);
      if (m_legal(st, f3, ea)) begin
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata} !==
            {1'b1, st, ea & 32'hFFFF_FFFC, st ? m_strb(f3, ea[1:0]) : 4'h0,
             st ? m_wdata(f3, wd) : 32'h0}) begin
          errors++;
          $display("FAIL b2b_mem[%0d] req=%b we=%b addr=%h strb=%b wdata=%h for st=%b f3=%b ea=%h",
                   i, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, st, f3, ea);
        end
        mem_respond(delay, rdata);
      end else begin
        checks++;
        if (mem_req !== 1'b0 || resp_valid !== 1'b1) begin
          errors++;
          $display("FAIL b2b_illegal[%0d] mem_req=%b resp_valid=%b required 0 1",
                   i, mem_req, resp_valid);
        end
      end
      wait_resp(obs);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL b2b_resp[%0d] got %h/%0d/%b required %h/%0d/%b (st=%b f3=%b ea=%h)", i,
                 obs.data, obs.rd, obs.err, exp.data, exp.rd, exp.err, st, f3, ea);
      end
      checks++;
      if (req_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d] req_ready=%b required 1", i, req_ready);
      end
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_is_store = 1'b0;
    req_func3    = 3'b000;
    req_base     = 32'h0;
    req_imm      = 32'h0;
    req_wdata    = 32'h0;
    req_rd       = 5'd0;
    mem_ack      = 1'b0;
    mem_rdata    = 32'h0;
    resp_ready   = 1'b0;
    test_reset();
    test_load_byte();
    test_load_half();
    test_store();
    test_errors();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
